// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - combinational round-robin bus arbiter with lock, debug override and RAM/IO decode
module mem_bus_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int LOCK_MAX       = 4
) (
  input  logic                        clk_in,
  input  logic                        rst_n_in,
  input  logic [NUM_MASTERS-1:0]      m_req,
  input  logic [NUM_MASTERS-1:0]      m_lock,
  input  logic [NUM_MASTERS*32-1:0]   m_a,
  input  logic [NUM_MASTERS-1:0]      m_wr,
  input  logic [NUM_MASTERS*8-1:0]    m_dout,
  output logic [NUM_MASTERS-1:0]      m_gnt,
  output logic [NUM_MASTERS-1:0]      m_rvalid,
  output logic [7:0]                  m_din,
  input  logic                        dbg_active,
  output logic                        ram_en,
  output logic                        ram_r_nw,
  output logic [RAM_ADDR_WIDTH-1:0]   ram_a,
  output logic [7:0]                  ram_d,
  input  logic [7:0]                  ram_q,
  output logic                        io_en,
  output logic [2:0]                  io_sel,
  output logic                        io_wr,
  output logic [7:0]                  io_d,
  input  logic [7:0]                  io_q,
  input  logic                        io_full
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = $clog2(LOCK_MAX) + 1;
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_MAX - 1);

  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] lock_idx_q, lock_idx_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic          locked_q, locked_d;
  logic          expired_q, expired_d;
  logic          rd_pend_q, rd_pend_d;
  logic          rd_io_q, rd_io_d;
  logic [IW-1:0] rd_idx_q, rd_idx_d;

  logic [NUM_MASTERS-1:0] elig, cand;
  logic                   gnt_any, gnt_io, sel_wr, cont;
  logic [IW-1:0]          gnt_idx, idx_w;
  logic [31:0]            sel_a;
  logic [7:0]             sel_d;
  logic [CW-1:0]          eff_cnt;
  logic                   unused_addr_bits;

  // Debug masks everyone but master 0; a blocked IO write simply drops out this cycle.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      elig[i] = m_req[i]
              & ~((m_a[i*32+RAM_ADDR_WIDTH -: 2] == 2'b11) & m_wr[i] & io_full)
              & (~dbg_active | (i == 0));
    end
  end

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = elig;
    idx_w   = '0;
    if (locked_q && elig[lock_idx_q]) begin
      gnt_any = 1'b1;
      gnt_idx = lock_idx_q;
    end else begin
      // A master whose lock just ran out yields to anyone else eligible.
      if (expired_q) cand[lock_idx_q] = 1'b0;
      if (cand == '0) cand = elig;
      for (int k = 0; k < NUM_MASTERS - 1; k++) begin
        idx_w = IW'(1 + ((int'(rr_ptr_q) + k) % (NUM_MASTERS - 1)));
        if (!gnt_any && cand[idx_w]) begin
          gnt_any = 1'b1;
          gnt_idx = idx_w;
        end
      end
      if (!gnt_any && cand[0]) begin
        gnt_any = 1'b1;
        gnt_idx = '0;
      end
    end
    if (!rst_n_in) gnt_any = 1'b0;
  end

  always_comb begin
    m_gnt  = '0;
    sel_a  = '0;
    sel_wr = 1'b0;
    sel_d  = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (gnt_any && gnt_idx == IW'(i)) begin
        m_gnt[i] = 1'b1;
        sel_a    = m_a[i*32 +: 32];
        sel_wr   = m_wr[i];
        sel_d    = m_dout[i*8 +: 8];
      end
    end
  end

  assign gnt_io           = sel_a[RAM_ADDR_WIDTH -: 2] == 2'b11;
  assign unused_addr_bits = ^sel_a[31:RAM_ADDR_WIDTH+1];
  assign ram_en           = gnt_any & ~gnt_io;
  assign ram_r_nw         = ~sel_wr;
  assign ram_a            = sel_a[RAM_ADDR_WIDTH-1:0];
  assign ram_d            = sel_d;
  assign io_en            = gnt_any & gnt_io;
  assign io_sel           = sel_a[2:0];
  assign io_wr            = gnt_any & gnt_io & sel_wr;
  assign io_d             = sel_d;

  always_comb begin
    cont       = gnt_any && locked_q && (gnt_idx == lock_idx_q);
    eff_cnt    = cont ? lock_cnt_q : '0;
    locked_d   = 1'b0;
    lock_cnt_d = '0;
    expired_d  = 1'b0;
    lock_idx_d = lock_idx_q;
    rr_ptr_d   = rr_ptr_q;
    if (gnt_any) begin
      lock_idx_d = gnt_idx;
      if (gnt_idx != '0) rr_ptr_d = gnt_idx;
      if (m_lock[gnt_idx]) begin
        if (eff_cnt < LOCK_LAST) begin
          locked_d   = 1'b1;
          lock_cnt_d = eff_cnt + 1'b1;
        end else begin
          expired_d = 1'b1;
        end
      end
    end
    rd_pend_d = gnt_any & ~sel_wr;
    rd_io_d   = gnt_io;
    rd_idx_d  = gnt_idx;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rr_ptr_q   <= '0;
      lock_idx_q <= '0;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
      expired_q  <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_io_q    <= 1'b0;
      rd_idx_q   <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_idx_q <= lock_idx_d;
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
      expired_q  <= expired_d;
      rd_pend_q  <= rd_pend_d;
      rd_io_q    <= rd_io_d;
      rd_idx_q   <= rd_idx_d;
    end
  end

  // Read data arrives one cycle after the grant; the source is picked by the region captured then.
  always_comb begin
    m_rvalid = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      m_rvalid[i] = rd_pend_q && (rd_idx_q == IW'(i));
    end
    m_din = !rd_pend_q ? 8'h00 : (rd_io_q ? io_q : ram_q);
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;
  localparam int N  = 3;
  localparam int AW = 17;

  logic            clk_in = 1'b0;
  logic            rst_n_in;
  logic [N-1:0]    m_req, m_lock, m_wr, m_gnt, m_rvalid;
  logic [N*32-1:0] m_a;
  logic [N*8-1:0]  m_dout;
  logic [7:0]      m_din, ram_d, ram_q, io_d, io_q;
  logic            dbg_active, ram_en, ram_r_nw, io_en, io_wr, io_full;
  logic [AW-1:0]   ram_a;
  logic [2:0]      io_sel;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  mem_bus_arbiter #(.NUM_MASTERS(N), .RAM_ADDR_WIDTH(AW), .LOCK_MAX(4)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .m_req(m_req), .m_lock(m_lock), .m_a(m_a), .m_wr(m_wr), .m_dout(m_dout),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_din(m_din), .dbg_active(dbg_active),
    .ram_en(ram_en), .ram_r_nw(ram_r_nw), .ram_a(ram_a), .ram_d(ram_d), .ram_q(ram_q),
    .io_en(io_en), .io_sel(io_sel), .io_wr(io_wr), .io_d(io_d), .io_q(io_q), .io_full(io_full)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_m(input int i, input logic req, input logic lock, input logic wr,
                       input logic [31:0] a, input logic [7:0] d);
    m_req[i]          = req;
    m_lock[i]         = lock;
    m_wr[i]           = wr;
    m_a[i*32 +: 32]   = a;
    m_dout[i*8 +: 8]  = d;
  endtask

  initial begin
    rst_n_in = 1'b0; m_req = '0; m_lock = '0; m_a = '0; m_wr = '0; m_dout = '0;
    dbg_active = 1'b0; ram_q = 8'h5C; io_q = 8'h3A; io_full = 1'b0;
    set_m(1, 1, 0, 0, 32'h10, 8'h00);
    set_m(2, 1, 0, 0, 32'h20, 8'h00);
    #3;
    chk("rst_gnt", m_gnt, 0);
    chk("rst_rvalid", m_rvalid, 0);
    chk("rst_din", m_din, 0);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_io_en", io_en, 0);
    chk("rst_io_wr", io_wr, 0);
    cyc();
    chk("rst_gnt_edge", m_gnt, 0);
    chk("rst_rvalid_edge", m_rvalid, 0);

    // round-robin reads from masters 1 and 2
    cyc(); rst_n_in = 1'b1; settle();
    chk("A0_gnt", m_gnt, 3'b010);
    chk("A0_ram_en", ram_en, 1);
    chk("A0_r_nw", ram_r_nw, 1);
    chk("A0_ram_a", ram_a, 32'h10);
    chk("A0_rvalid", m_rvalid, 0);
    cyc(); ram_q = 8'h11; settle();
    chk("A1_gnt", m_gnt, 3'b100);
    chk("A1_ram_a", ram_a, 32'h20);
    chk("A1_rvalid", m_rvalid, 3'b010);
    chk("A1_din", m_din, 8'h11);
    cyc(); ram_q = 8'h22; settle();
    chk("A2_gnt", m_gnt, 3'b010);
    chk("A2_rvalid", m_rvalid, 3'b100);
    chk("A2_din", m_din, 8'h22);
    cyc(); ram_q = 8'h33; settle();
    chk("A3_gnt", m_gnt, 3'b100);
    chk("A3_rvalid", m_rvalid, 3'b010);
    chk("A3_din", m_din, 8'h33);
    cyc(); m_req = '0; ram_q = 8'h44; settle();
    chk("A4_gnt", m_gnt, 0);
    chk("A4_ram_en", ram_en, 0);
    chk("A4_rvalid", m_rvalid, 3'b100);
    chk("A4_din", m_din, 8'h44);
    cyc(); settle();
    chk("A5_rvalid", m_rvalid, 0);
    chk("A5_din", m_din, 0);

    // IO read then RAM read, region taken from grant time
    cyc(); set_m(1, 1, 0, 0, 32'h30000, 8'h00); settle();
    chk("B0_gnt", m_gnt, 3'b010);
    chk("B0_io_en", io_en, 1);
    chk("B0_io_sel", io_sel, 0);
    chk("B0_ram_en", ram_en, 0);
    chk("B0_io_wr", io_wr, 0);
    cyc(); m_req[1] = 1'b0; set_m(2, 1, 0, 0, 32'h10, 8'h00); io_q = 8'h5A; ram_q = 8'hEE; settle();
    chk("B1_gnt", m_gnt, 3'b100);
    chk("B1_ram_en", ram_en, 1);
    chk("B1_rvalid", m_rvalid, 3'b010);
    chk("B1_din", m_din, 8'h5A);
    cyc(); m_req = '0; io_q = 8'h77; ram_q = 8'hC3; settle();
    chk("B2_gnt", m_gnt, 0);
    chk("B2_rvalid", m_rvalid, 3'b100);
    chk("B2_din", m_din, 8'hC3);

    // master 1 lock, LOCK_MAX=4
    cyc(); set_m(1, 1, 1, 0, 32'h100, 8'h00); set_m(2, 1, 0, 0, 32'h200, 8'h00); settle();
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("C%0d_gnt", c), m_gnt, 3'b010);
      cyc(); settle();
    end
    chk("C4_gnt", m_gnt, 3'b100);
    cyc(); settle();
    chk("C5_gnt", m_gnt, 3'b010);
    cyc(); m_req = '0; m_lock = '0; settle();
    chk("C6_gnt", m_gnt, 0);

    // IO write held off by io_full
    cyc(); io_full = 1'b1; set_m(1, 1, 0, 1, 32'h30000, 8'hA5); settle();
    chk("D0_gnt", m_gnt, 0);
    chk("D0_io_wr", io_wr, 0);
    chk("D0_io_en", io_en, 0);
    cyc(); set_m(2, 1, 0, 0, 32'h50, 8'h00); settle();
    chk("D1_gnt_skip", m_gnt, 3'b100);
    chk("D1_io_wr", io_wr, 0);
    cyc(); m_req[2] = 1'b0; io_full = 1'b0; settle();
    chk("D2_gnt", m_gnt, 3'b010);
    chk("D2_io_en", io_en, 1);
    chk("D2_io_wr", io_wr, 1);
    chk("D2_io_sel", io_sel, 0);
    chk("D2_io_d", io_d, 8'hA5);
    chk("D2_rvalid", m_rvalid, 3'b100);
    cyc(); m_req = '0; m_wr = '0; settle();
    chk("D3_rvalid_wr", m_rvalid, 0);

    // debug break during master 1 lock
    cyc(); set_m(1, 1, 1, 0, 32'h300, 8'h00); set_m(0, 1, 0, 0, 32'h400, 8'h00); settle();
    chk("E0_gnt", m_gnt, 3'b010);
    cyc(); settle();
    chk("E1_gnt", m_gnt, 3'b010);
    cyc(); dbg_active = 1'b1; settle();
    chk("E2_gnt", m_gnt, 3'b001);
    chk("E2_ram_a", ram_a, 32'h400);
    cyc(); settle();
    chk("E3_gnt", m_gnt, 3'b001);
    cyc(); dbg_active = 1'b0; settle();
    chk("E4_gnt", m_gnt, 3'b010);
    cyc(); m_req = '0; m_lock = '0; settle();
    chk("E5_gnt", m_gnt, 0);

    // reset pulse right after a read grant
    cyc(); set_m(1, 1, 0, 0, 32'h40, 8'h00); settle();
    chk("F0_gnt", m_gnt, 3'b010);
    cyc(); rst_n_in = 1'b0; ram_q = 8'h99; settle();
    chk("F1_rvalid", m_rvalid, 0);
    chk("F1_gnt", m_gnt, 0);
    chk("F1_din", m_din, 0);
    chk("F1_ram_en", ram_en, 0);
    chk("F1_io_en", io_en, 0);
    chk("F1_io_wr", io_wr, 0);
    cyc(); rst_n_in = 1'b1; m_req = '0; settle();
    chk("F2_rvalid", m_rvalid, 0);
    cyc(); settle();
    chk("F3_rvalid", m_rvalid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
